// File: rtl/demux4_rr_dispatcher.sv
// Round-robin dispatcher in front of a 1-to-4 demux: holds one item and steers it
// to the next enabled channel, honouring per-channel back-pressure.
module demux4_rr_dispatcher #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  input  logic [3:0]    i_ch_en,
  output logic [1:0]    o_sel,
  output logic [DW-1:0] o_out_data,
  output logic [3:0]    o_out_valid,
  input  logic [3:0]    i_out_ready,
  output logic          o_busy,
  output logic [CW-1:0] o_xfer_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_sel;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] r_xfer_cnt;

  logic       w_any_en;
  logic       w_done;
  logic       w_accept;
  logic [1:0] w_search_base;
  logic [1:0] w_target;

  assign w_any_en = |i_ch_en;
  assign w_done   = (r_state == ST_FULL) && i_out_ready[r_sel];
  assign w_accept = i_in_valid && o_in_ready;

  // A back-to-back capture must start searching after the channel just served,
  // which is the same value ptr is about to take.
  assign w_search_base = (r_state == ST_FULL) ? (r_sel + 2'd1) : r_ptr;

  // Scan downwards so the nearest enabled channel to the base wins.
  always_comb begin
    w_target = w_search_base;
    for (int k = 3; k >= 0; k--) begin
      if (i_ch_en[w_search_base + 2'(k)]) begin
        w_target = w_search_base + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= 2'd0;
      r_sel      <= 2'd0;
      r_out_data <= '0;
      r_xfer_cnt <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_data <= i_in_data;
            r_sel      <= w_target;
            r_state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_done) begin
            r_ptr      <= r_sel + 2'd1;
            r_xfer_cnt <= r_xfer_cnt + CW'(1);
            if (w_accept) begin
              r_out_data <= i_in_data;
              r_sel      <= w_target;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Readiness looks through to the consumer so a draining slot can refill in the same cycle.
  assign o_in_ready  = rst_n && w_any_en && ((r_state == ST_EMPTY) || w_done);
  assign o_sel       = r_sel;
  assign o_out_data  = r_out_data;
  assign o_out_valid = (r_state == ST_FULL) ? (4'b0001 << r_sel) : 4'b0000;
  assign o_busy      = (r_state == ST_FULL);
  assign o_xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Directed bench for demux4_rr_dispatcher: a one-slot behavioural model is compared
// against the DUT on every falling edge, with literal checks pinning each scenario.
module tb_demux4_rr_dispatcher;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [3:0]    chEn;
  logic [1:0]    sel;
  logic [DW-1:0] outData;
  logic [3:0]    outValid;
  logic [3:0]    outReady;
  logic          busy;
  logic [CW-1:0] xferCnt;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  bit mHeld = 1'b0;
  int mSel  = 0;
  int mPtr  = 0;
  int mData = 0;
  int mCnt  = 0;

  demux4_rr_dispatcher #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_data   (inData),
    .i_ch_en     (chEn),
    .o_sel       (sel),
    .o_out_data  (outData),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_busy      (busy),
    .o_xfer_cnt  (xferCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input int en, input int rdy);
    inValid  = v;
    inData   = DW'(d);
    chEn     = 4'(en);
    outReady = 4'(rdy);
    @(posedge clk);
    #1;
  endtask

  // Model: a single slot; a held item leaves when its consumer is ready, and a new
  // item goes to the first enabled channel at or after the one following the last served.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHeld = 1'b0;
      mSel  = 0;
      mPtr  = 0;
      mData = 0;
      mCnt  = 0;
    end else begin
      bit delivered;
      bit canTake;
      bit found;
      delivered = mHeld && outReady[mSel];
      canTake   = (chEn != 4'b0) && (!mHeld || delivered);
      if (delivered) begin
        mCnt  = (mCnt + 1) % (1 << CW);
        mPtr  = (mSel + 1) % 4;
        mHeld = 1'b0;
      end
      if (inValid && canTake) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && chEn[(mPtr + k) % 4]) begin
            found = 1'b1;
            mSel  = (mPtr + k) % 4;
          end
        end
        mData = inData;
        mHeld = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_out_valid", outValid, mHeld ? (1 << mSel) : 0);
      checkOutput("m_busy", busy, mHeld);
      checkOutput("m_sel", sel, mSel);
      checkOutput("m_out_data", outData, mData);
      checkOutput("m_xfer_cnt", xferCnt, mCnt);
      checkOutput("m_in_ready", inReady,
                  (rst_n && chEn != 4'b0 && (!mHeld || outReady[mSel])) ? 1 : 0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t1Data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int t1Sel  [5] = '{0, 1, 2, 3, 0};
    int t2Sel  [4] = '{1, 3, 1, 3};
    int tabV   [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int tabEn  [8] = '{4'h9, 4'h9, 4'h6, 4'h6, 4'hF, 4'h1, 4'h8, 4'h0};
    int tabRdy [8] = '{4'h0, 4'hF, 4'h2, 4'h4, 4'h1, 4'hF, 4'h8, 4'hF};

    rst_n    = 1'b1;
    inValid  = 1'b0;
    inData   = '0;
    chEn     = 4'hF;
    outReady = 4'h0;
    #2 rst_n = 1'b0;
    checkEn  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_xfer_cnt", xferCnt, 0);
    checkOutput("rst_in_ready", inReady, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", inReady, 1);

    $display("[TB] back-to-back round robin over all channels");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, t1Data[i], 4'hF, 4'hF);
      checkOutput("t1_sel", sel, t1Sel[i]);
      checkOutput("t1_out_valid", outValid, 1 << t1Sel[i]);
      checkOutput("t1_out_data", outData, t1Data[i]);
      checkOutput("t1_in_ready", inReady, 1);
    end
    applyStimulus(0, 0, 4'hF, 4'hF);
    checkOutput("t1_xfer_cnt", xferCnt, 5);
    checkOutput("t1_busy", busy, 0);

    $display("[TB] sparse enable mask 1010");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'hA1 + i, 4'hA, 4'hF);
      checkOutput("t2_sel", sel, t2Sel[i]);
      checkOutput("t2_out_valid", outValid, 1 << t2Sel[i]);
    end
    applyStimulus(0, 0, 4'hA, 4'hF);
    checkOutput("t2_xfer_cnt", xferCnt, 9);

    $display("[TB] back-pressure on channel 2");
    applyStimulus(1, 8'hA5, 4'hC, 4'hB);
    checkOutput("t3_capture_sel", sel, 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h5A, 4'hC, 4'hB);
      checkOutput("t3_hold_valid", outValid, 4'h4);
      checkOutput("t3_hold_data", outData, 8'hA5);
      checkOutput("t3_hold_in_ready", inReady, 0);
      checkOutput("t3_hold_busy", busy, 1);
    end
    applyStimulus(1, 8'h5A, 4'hC, 4'hF);
    checkOutput("t3_next_sel", sel, 3);
    checkOutput("t3_next_data", outData, 8'h5A);
    checkOutput("t3_xfer_cnt", xferCnt, 10);
    applyStimulus(0, 0, 4'hC, 4'hF);
    checkOutput("t3_drain_cnt", xferCnt, 11);

    $display("[TB] no channel enabled, then retarget-free delivery");
    applyStimulus(1, 8'h77, 4'h0, 4'hF);
    checkOutput("t4_in_ready_off", inReady, 0);
    checkOutput("t4_busy_off", busy, 0);
    applyStimulus(1, 8'h77, 4'h4, 4'h0);
    checkOutput("t4_capture_sel", sel, 2);
    checkOutput("t4_capture_busy", busy, 1);
    applyStimulus(0, 0, 4'h0, 4'h0);
    checkOutput("t4_held_valid", outValid, 4'h4);
    applyStimulus(0, 0, 4'h0, 4'h4);
    checkOutput("t4_delivered_busy", busy, 0);
    checkOutput("t4_xfer_cnt", xferCnt, 12);

    $display("[TB] asynchronous reset while full");
    applyStimulus(1, 8'h99, 4'h2, 4'h0);
    checkOutput("t5_pre_valid", outValid, 4'h2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", outValid, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_sel", sel, 0);
    checkOutput("t5_rst_cnt", xferCnt, 0);
    checkOutput("t5_rst_in_ready", inReady, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 8'h33, 4'hF, 4'hF);
    checkOutput("t5_after_sel", sel, 0);
    checkOutput("t5_after_valid", outValid, 4'h1);
    applyStimulus(0, 0, 4'hF, 4'hF);
    checkOutput("t5_after_cnt", xferCnt, 1);

    $display("[TB] transfer counter wrap");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'hC0 + i, 4'hF, 4'hF);
    end
    applyStimulus(0, 0, 4'hF, 4'hF);
    checkOutput("t6_wrap_cnt", xferCnt, 1);

    $display("[TB] mixed enable/ready table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tabV[i] != 0, 8'hE0 + i, tabEn[i], tabRdy[i]);
    end
    applyStimulus(0, 0, 4'hF, 4'hF);
    applyStimulus(0, 0, 4'hF, 4'hF);

    checkEn = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
